// File: rtl/cbx_pkg.sv
// Shared definitions for the cbx_param connection block: channel geometry,
// derived mux/select/chain sizes and the tap index helper.
// Optional build macro: CBX_CFG_PARITY_EN adds an even-parity bit to the chain.
package cbx_pkg;

   localparam int CHAN_W = 4;   // tracks per direction, divisible by TAPS
   localparam int N_IPIN = 7;   // grid input pins driven
   localparam int TAPS   = 2;   // tracks tapped per pin per side

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r = r + 1;
      return r;
   endfunction

   localparam int M     = 2 * TAPS;
   localparam int SEL_W = clog2(M);
   localparam int CFG_W = N_IPIN * SEL_W;
`ifdef CBX_CFG_PARITY_EN
   localparam int L     = CFG_W + 1;
`else
   localparam int L     = CFG_W;
`endif
   localparam int CNT_W = clog2(L + 1);

   // Track tapped by pin i on tap k; taps are spread evenly across the channel.
   function automatic int tap_idx(input int i, input int k);
      return (i + k * (CHAN_W / TAPS)) % CHAN_W;
   endfunction

endpackage

// File: rtl/cbx_param_if.sv
// Configuration chain and channel/pin bundle of the cbx_param block.
// master = the side driving chain and channel inputs, slave = the block.
interface cbx_param_if;
   import cbx_pkg::*;

   logic              ccff_en;
   logic              ccff_head;
   logic              ccff_tail;
   logic              cfg_commit;
   logic              cfg_done;
   logic              cfg_valid;
   logic              cfg_err;
   logic [CHAN_W-1:0] chanx_left_in;
   logic [CHAN_W-1:0] chanx_right_in;
   logic [CHAN_W-1:0] chanx_left_out;
   logic [CHAN_W-1:0] chanx_right_out;
   logic [N_IPIN-1:0] ipin_out;

   modport master (
      output ccff_en, ccff_head, cfg_commit, chanx_left_in, chanx_right_in,
      input  ccff_tail, cfg_done, cfg_valid, cfg_err,
             chanx_left_out, chanx_right_out, ipin_out
   );

   modport slave (
      input  ccff_en, ccff_head, cfg_commit, chanx_left_in, chanx_right_in,
      output ccff_tail, cfg_done, cfg_valid, cfg_err,
             chanx_left_out, chanx_right_out, ipin_out
   );

endinterface

// File: rtl/cbx_tap_mux.sv
// M-input tap mux for one grid pin; select codes at or above M give 0.
module cbx_tap_mux #(
   parameter int M     = 4,
   parameter int SEL_W = 2
) (
   input  logic [M-1:0]     din,
   input  logic [SEL_W-1:0] sel,
   output logic             dout
);

   localparam int N_SEL = 1 << SEL_W;

   logic [N_SEL-1:0] ext;

   // Zero-extend the inputs to the full select range so unused codes read 0.
   always_comb begin
      ext        = '0;
      ext[M-1:0] = din;
   end

   assign dout = ext[sel];

endmodule

// File: rtl/cbx_param.sv
// cbx_param: X-channel connection block. Tracks pass straight through; each
// grid pin picks one tapped track via a mux whose select is loaded over a
// serial chain into a shadow register and committed atomically to the
// active register, so pins never glitch while the chain is programmed.
// Optional build macro: CBX_CFG_PARITY_EN (even-parity check on commit).
module cbx_param
   import cbx_pkg::*;
(
   input  logic        prog_clk,
   input  logic        prog_reset_n,
   cbx_param_if.slave  bus
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(L);

   logic [L-1:0]      sr;
   logic [CFG_W-1:0]  active;
   logic [CNT_W-1:0]  cnt;
   logic              cfg_valid;
   logic              cfg_done;
   logic [N_IPIN-1:0] pin;

   assign cfg_done = (cnt == CNT_MAX);

   // Shadow chain: shifts whenever enabled, never reset, keeps passing bits
   // downstream after the counter saturates.
   always_ff @(posedge prog_clk) begin
      if (bus.ccff_en) sr <= {sr[L-2:0], bus.ccff_head};
   end

`ifdef CBX_CFG_PARITY_EN
   logic cfg_err;

   // Shift counter and commit; a commit with odd chain parity is rejected.
   always_ff @(posedge prog_clk or negedge prog_reset_n) begin
      if (!prog_reset_n) begin
         cnt       <= '0;
         active    <= '0;
         cfg_valid <= 1'b0;
         cfg_err   <= 1'b0;
      end else if (bus.ccff_en) begin
         if (!cfg_done) cnt <= cnt + 1'b1;
      end else if (bus.cfg_commit && cfg_done) begin
         cnt <= '0;
         if (^sr) begin
            cfg_err <= 1'b1;
         end else begin
            active    <= sr[CFG_W-1:0];
            cfg_valid <= 1'b1;
            cfg_err   <= 1'b0;
         end
      end
   end
`else
   logic cfg_err;
   assign cfg_err = 1'b0;

   // Shift counter and commit; a shift in the same cycle wins over a commit.
   always_ff @(posedge prog_clk or negedge prog_reset_n) begin
      if (!prog_reset_n) begin
         cnt       <= '0;
         active    <= '0;
         cfg_valid <= 1'b0;
      end else if (bus.ccff_en) begin
         if (!cfg_done) cnt <= cnt + 1'b1;
      end else if (bus.cfg_commit && cfg_done) begin
         cnt       <= '0;
         active    <= sr[CFG_W-1:0];
         cfg_valid <= 1'b1;
      end
   end
`endif

   for (genvar i = 0; i < N_IPIN; i++) begin : g_pin
      logic [M-1:0] tin;
      logic         mo;

      for (genvar k = 0; k < TAPS; k++) begin : g_tap
         assign tin[2*k]   = bus.chanx_left_in[tap_idx(i, k)];
         assign tin[2*k+1] = bus.chanx_right_in[tap_idx(i, k)];
      end

      cbx_tap_mux #(.M(M), .SEL_W(SEL_W)) u_mux (
         .din  (tin),
         .sel  (active[i*SEL_W +: SEL_W]),
         .dout (mo)
      );

      // Pins stay low until a configuration has been committed.
      assign pin[i] = cfg_valid & mo;
   end

   assign bus.ccff_tail       = sr[L-1];
   assign bus.cfg_done        = cfg_done;
   assign bus.cfg_valid       = cfg_valid;
   assign bus.cfg_err         = cfg_err;
   assign bus.chanx_left_out  = bus.chanx_right_in;
   assign bus.chanx_right_out = bus.chanx_left_in;
   assign bus.ipin_out        = pin;

endmodule
